lsu_mem_ctrl: RTL

- Load/store unit between the execute stage and data_mem, directly upstream of the memory.
- Accepts one byte/half/word request at a time over a valid/ready handshake and translates it into data_mem's word-only, registered-address port.
- Sub-word stores are done as read-modify-write.
- Returns sign/zero-extended load data, or a store acknowledge, over a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_byte_lane.sv | 54 +++++
 rtl/lsu_mem_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// and request classification helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    // Stores only exist as B/H/W; loads reject the unused encodings 3, 6, 7.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 > F3_W;
        end
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // Halfword needs addr[0] = 0, word needs addr[1:0] = 0.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] mem_dout,
    input  logic [15:0] wdata_lo,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_c,
    output logic [31:0] merge_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Select the addressed lane and extend it according to funct3.
    always_comb begin
        case (off)
            2'd0:    byte_c = mem_dout[7:0];
            2'd1:    byte_c = mem_dout[15:8];
            2'd2:    byte_c = mem_dout[23:16];
            default: byte_c = mem_dout[31:24];
        endcase
        half_c = off[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (funct3)
            F3_B:    load_c = {{24{byte_c[7]}}, byte_c};
            F3_BU:   load_c = {24'd0, byte_c};
            F3_H:    load_c = {{16{half_c[15]}}, half_c};
            F3_HU:   load_c = {16'd0, half_c};
            default: load_c = mem_dout;
        endcase
    end

    // Overlay the store lane onto the word read back from memory.
    always_comb begin
        merge_c = mem_dout;
        case (funct3)
            F3_B: begin
                case (off)
                    2'd0:    merge_c[7:0]   = wdata_lo[7:0];
                    2'd1:    merge_c[15:8]  = wdata_lo[7:0];
                    2'd2:    merge_c[23:16] = wdata_lo[7:0];
                    default: merge_c[31:24] = wdata_lo[7:0];
                endcase
            end
            F3_H: begin
                if (off[1]) merge_c[31:16] = wdata_lo;
                else        merge_c[15:0]  = wdata_lo;
            end
            default: merge_c = mem_dout;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a word-only, registered-address data memory.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDRW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_lo_q, wdata_lo_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;

    logic        req_bad_c;
    logic [31:0] load_c;
    logic [31:0] merge_c;
    logic        unused_addr_hi;

    // Address bits above ADDRW never reach the memory.
    assign unused_addr_hi = ^req_addr[31:ADDRW];

    lsu_byte_lane u_lane (
        .mem_dout (mem_dout),
        .wdata_lo (wdata_lo_q),
        .off      (off_q),
        .funct3   (f3_q),
        .load_c   (load_c),
        .merge_c  (merge_c)
    );

    // Classify the incoming request as one that must not touch memory.
    always_comb begin
        req_bad_c = f3_illegal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad_c = req_bad_c | f3_misaligned(req_funct3, req_addr[1:0]);
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        wdata_lo_d   = wdata_lo_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    f3_d       = req_funct3;
                    off_d      = req_addr[1:0];
                    wdata_lo_d = req_wdata[15:0];
                    if (req_bad_c) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 32'd0;
                        state_d      = ST_RESP;
                    end else begin
                        // Word address is held in mem_addr for RD and WR.
                        mem_addr_d = 32'({req_addr[ADDRW-1:2], 2'b00});
                        if (req_we && (req_funct3 == F3_W)) begin
                            mem_we_d  = 1'b1;
                            mem_din_d = req_wdata;
                            state_d   = ST_WR;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                if (we_q) begin
                    mem_din_d = merge_c;
                    mem_we_d  = 1'b1;
                    state_d   = ST_WR;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_c;
                    resp_err_d   = 1'b0;
                    state_d      = ST_RESP;
                end
            end
            ST_WR: begin
                resp_valid_d = 1'b1;
                resp_data_d  = 32'd0;
                resp_err_d   = 1'b0;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            wdata_lo_q   <= 16'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            wdata_lo_q   <= wdata_lo_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;

endmodule
